// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - configurable UART transmitter (baud, data width, parity, stop bits, cts handshake)
module uart_tx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] controls,
  input  logic [7:0] data,
  input  logic       start,
  input  logic       cts,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int DIV_7200   = CLK_FREQ / 7200;
  localparam int DIV_9600   = CLK_FREQ / 9600;
  localparam int DIV_19200  = CLK_FREQ / 19200;
  localparam int DIV_115200 = CLK_FREQ / 115200;
  localparam int CW         = $clog2(DIV_7200 + 1);

  typedef enum logic [2:0] {IDLE, WAIT_CTS, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] div_l;
  logic [CW-1:0] div_sel;
  logic [2:0]    idx;
  logic [2:0]    nlast;
  logic [7:0]    data_l;
  logic [7:0]    mask;
  logic          stop2;
  logic          pen;
  logic          pmode;
  logic          second_stop;
  logic          fin;
  logic          cts_q1;
  logic          cts_q2;
  logic          bit_end;
  logic          par;

  always_comb begin
    div_sel = CW'(DIV_115200);
    mask    = 8'hFF;
    case (controls[7:6])
      2'b00:   div_sel = CW'(DIV_7200);
      2'b01:   div_sel = CW'(DIV_9600);
      2'b10:   div_sel = CW'(DIV_19200);
      default: div_sel = CW'(DIV_115200);
    endcase
    case (controls[3:2])
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
  end

  assign bit_end = (cnt == div_l - CW'(1));
  // Unused upper data bits are masked off at latch time, so they cannot reach parity.
  assign par     = (^data_l) ^ ~pmode;

  // Outputs are registered from the current state, so every line value lags the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      div_l       <= '0;
      idx         <= '0;
      nlast       <= '0;
      data_l      <= '0;
      stop2       <= 1'b0;
      pen         <= 1'b0;
      pmode       <= 1'b0;
      second_stop <= 1'b0;
      fin         <= 1'b0;
      cts_q1      <= 1'b0;
      cts_q2      <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      cts_q1 <= cts;
      cts_q2 <= cts_q1;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          tx          <= 1'b1;
          busy        <= 1'b0;
          done        <= fin;
          fin         <= 1'b0;
          cnt         <= '0;
          idx         <= '0;
          second_stop <= 1'b0;
          if (start) begin
            data_l <= data & mask;
            div_l  <= div_sel;
            nlast  <= 3'd4 + {1'b0, controls[3:2]};
            stop2  <= controls[5];
            pen    <= controls[0];
            pmode  <= controls[1];
            state  <= (controls[4] && !cts_q2) ? WAIT_CTS : START;
          end
        end
        WAIT_CTS: begin
          tx   <= 1'b1;
          busy <= 1'b1;
          if (cts_q2) state <= START;
        end
        START: begin
          tx   <= 1'b0;
          busy <= 1'b1;
          if (bit_end) state <= DATA;
        end
        DATA: begin
          tx   <= data_l[idx];
          busy <= 1'b1;
          if (bit_end) begin
            if (idx == nlast) begin
              idx   <= '0;
              state <= pen ? PARITY : STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        PARITY: begin
          tx   <= par;
          busy <= 1'b1;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          tx   <= 1'b1;
          busy <= 1'b1;
          if (bit_end) begin
            if (stop2 && !second_stop) begin
              second_stop <= 1'b1;
            end else begin
              state <= IDLE;
              fin   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (state == START || state == DATA || state == PARITY || state == STOP)
        cnt <= bit_end ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx: queued expected frames checked by a line monitor
module tb_uart_tx;

  localparam int CLK = 5_000_000;
  localparam int D115 = CLK / 115200;
  localparam int D96  = CLK / 9600;
  localparam int D192 = CLK / 19200;

  typedef struct {
    logic [11:0] bits;
    int          nb;
    int          div;
    int          id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] controls;
  logic [7:0] data;
  logic       start;
  logic       cts;
  logic       tx;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int n_push = 0;
  int frames_seen = 0;
  int frames_done = 0;
  int done_pulses = 0;
  int cyc = 0;
  int done_cyc = 0;
  int last_gap = 0;

  exp_t q[$];
  exp_t cur;
  bit active = 1'b0;
  bit ign = 1'b0;
  bit busy_ok;
  int pos;
  logic [11:0] of, ol;

  uart_tx #(.CLK_FREQ(CLK)) dut (
    .clk(clk), .rst(rst), .controls(controls), .data(data), .start(start),
    .cts(cts), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line monitor: samples first and last cycle of every bit, then the done cycle.
  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) done_pulses++;
    if (!rst) begin
      active = 1'b0;
      ign = 1'b0;
    end else begin
      if (ign && tx === 1'b1) ign = 1'b0;
      if (!active && !ign && tx === 1'b0) begin
        frames_seen++;
        chk("frame_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          active = 1'b1;
          pos = 0;
          of = '0;
          ol = '0;
          busy_ok = 1'b1;
          last_gap = cyc - done_cyc;
        end else begin
          ign = 1'b1;
        end
      end
      if (active) begin
        if (pos < cur.nb * cur.div) begin
          if (pos % cur.div == 0) of[pos / cur.div] = tx;
          if (pos % cur.div == cur.div - 1) ol[pos / cur.div] = tx;
          if (busy !== 1'b1) busy_ok = 1'b0;
          pos++;
        end else begin
          chk($sformatf("frame%0d_bits_first", cur.id), int'(of), int'(cur.bits));
          chk($sformatf("frame%0d_bits_last", cur.id), int'(ol), int'(cur.bits));
          chk($sformatf("frame%0d_busy", cur.id), busy_ok, 1);
          chk($sformatf("frame%0d_done_busy", cur.id), {done, busy}, 2'b10);
          frames_done++;
          done_cyc = cyc;
          active = 1'b0;
        end
      end
    end
  end

  task automatic push(input logic [11:0] bits, input int nb, input int div);
    exp_t e;
    e.bits = bits;
    e.nb = nb;
    e.div = div;
    e.id = n_push;
    q.push_back(e);
    n_push++;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    controls = c;
    data = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int b = 0;
    while (frames_done < n && b < 20000) begin
      @(posedge clk);
      b++;
    end
    chk("frame_timeout", frames_done >= n, 1);
  endtask

  initial begin
    int n;
    bit hs_ok;
    rst = 1'b1; start = 1'b0; cts = 1'b1; controls = 8'h00; data = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 at 115200, 0xA5, with start latency
    push(12'h34A, 10, D115);
    controls = 8'hCC; data = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    chk("lat_k_tx", tx, 1);
    chk("lat_k_busy", busy, 0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("lat_k1_tx", tx, 0);
    chk("lat_k1_busy", busy, 1);
    wait_frames(1);

    // 5E2 at 9600, upper data bits ignored
    push(12'h1FE, 9, D96);
    send(8'h63, 8'hFF);
    wait_frames(2);

    // 7O1 at 19200, controls/data changed mid-frame
    push(12'h306, 10, D192);
    send(8'h89, 8'h03);
    repeat (500) @(negedge clk);
    controls = 8'h00; data = 8'hFF;
    wait_frames(3);

    // handshake
    cts = 1'b0;
    repeat (4) @(negedge clk);
    push(12'h278, 10, D115);
    send(8'hDC, 8'h3C);
    hs_ok = 1'b1;
    repeat (1000) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b1) hs_ok = 1'b0;
    end
    chk("hs_hold", hs_ok, 1);
    @(negedge clk); cts = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (tx === 1'b1 && n < 20);
    chk("hs_edges_incl_sampling", n, 4);
    repeat (100) @(negedge clk);
    cts = 1'b0;
    wait_frames(4);
    cts = 1'b1;

    // start pulses while busy
    push(12'h302, 10, D115);
    send(8'hCC, 8'h81);
    repeat (3) begin
      repeat (100) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_frames(5);
    repeat (300) @(negedge clk);

    // back-to-back with start held high
    push(12'h21E, 10, D115);
    push(12'h3E0, 10, D115);
    @(negedge clk);
    controls = 8'hCC; data = 8'h0F; start = 1'b1;
    repeat (100) @(negedge clk);
    data = 8'hF0;
    wait_frames(6);
    @(negedge clk);
    start = 1'b0;
    wait_frames(7);
    chk("b2b_gap", last_gap, 1);
    repeat (100) @(negedge clk);

    // reset mid-frame, then a clean frame
    push(12'h354, 10, D115);
    send(8'hCC, 8'hAA);
    repeat (100) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push(12'h2AA, 10, D115);
    send(8'hCC, 8'h55);
    wait_frames(8);
    repeat (100) @(negedge clk);

    chk("frames_seen", frames_seen, n_push);
    chk("done_pulses", done_pulses, 8);
    chk("queue_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
